// File: rtl/gpio_in_debounce_pkg.sv
// Shared GPIO input constants and types, also used by the MCS top level.
package gpio_in_debounce_pkg;

    localparam int GPIO_WIDTH    = 8;
    localparam int DB_CYCLES_1MS = 32000;
    localparam int DB_CNT_W      = 15;

    // Registered edge pulses produced by one debounced bit
    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

endpackage

// File: rtl/gpio_in_debounce_if.sv
// Pin-side / firmware-side signal bundle of the GPIO input conditioner.
interface gpio_in_debounce_if
    import gpio_in_debounce_pkg::*;
#(
    parameter int WIDTH = GPIO_WIDTH
);
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             chg;
    logic             chg_clr;

    modport master (output din, output chg_clr, input dout, input rise, input fall, input chg);
    modport slave  (input din, input chg_clr, output dout, output rise, output fall, output chg);
endinterface

// File: rtl/gpio_in_debounce_bit.sv
// Single-bit 2-FF synchroniser, stability counter, debounced level and edge pulses.
// Latency: din step reaches dout DB_CYCLES+2 clocks later. No backpressure.
// Any return to the accepted level restarts the count from zero.
module debounce_bit
    import gpio_in_debounce_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_1MS,
    parameter int CNT_W     = DB_CNT_W
) (
    input  logic  clk,
    input  logic  resetb,
    input  logic  din,
    output logic  dout,
    output edge_t edges
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
            edges <= '0;
        end else begin
            s1    <= din;
            s2    <= s1;
            edges <= '0;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Accept the new level; pulse fires together with the level change
                dout       <= s2;
                cnt        <= '0;
                edges.rise <= s2;
                edges.fall <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/gpio_in_debounce.sv
// Per-bit synchronise/debounce/edge-detect of raw pins plus a sticky change flag for firmware.
// Latency: dout DB_CYCLES+2 clocks after a clean din step; chg one clock after the edge pulse.
// No backpressure: outputs are levels/pulses; chg holds until chg_clr (a new event beats a clear).
module gpio_in_debounce
    import gpio_in_debounce_pkg::*;
#(
    parameter int WIDTH     = GPIO_WIDTH,
    parameter int DB_CYCLES = DB_CYCLES_1MS,
    parameter int CNT_W     = DB_CNT_W
) (
    input  logic                clk,
    input  logic                resetb,
    gpio_in_debounce_if.slave   bus
);
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             chg;
    logic             any_edge;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        edge_t edg;

        debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_bit (
            .clk    (clk),
            .resetb (resetb),
            .din    (bus.din[i]),
            .dout   (dout[i]),
            .edges  (edg)
        );

        assign rise[i] = edg.rise;
        assign fall[i] = edg.fall;
    end

    assign any_edge = |(rise | fall);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            chg <= 1'b0;
        end else if (any_edge) begin
            chg <= 1'b1;
        end else if (bus.chg_clr) begin
            chg <= 1'b0;
        end
    end

    assign bus.dout = dout;
    assign bus.rise = rise;
    assign bus.fall = fall;
    assign bus.chg  = chg;
endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce with DB_CYCLES=8, so a clean step lands 10 clocks later.
module tb_gpio_in_debounce;
    logic clk;
    logic resetb;
    int   errors = 0;
    int   checks = 0;

    gpio_in_debounce_if #(.WIDTH(8)) bus ();

    gpio_in_debounce #(
        .WIDTH     (8),
        .DB_CYCLES (8),
        .CNT_W     (4)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        int rise_cnt;
        int fall_cnt;
        int bad_lvl;
        int first;

        // Reset with all pins high
        resetb      = 1'b0;
        bus.din     = 8'hFF;
        bus.chg_clr = 1'b0;
        tick(3);
        check("rst_dout", 32'(bus.dout), 32'h00);
        check("rst_rise", 32'(bus.rise), 32'h00);
        check("rst_fall", 32'(bus.fall), 32'h00);
        check("rst_chg",  32'(bus.chg),  32'h0);
        resetb = 1'b1;
        tick(9);
        check("rel_dout_early", 32'(bus.dout), 32'h00);
        tick(1);
        check("rel_dout", 32'(bus.dout), 32'hFF);
        check("rel_rise", 32'(bus.rise), 32'hFF);
        tick(1);
        check("rel_rise_off", 32'(bus.rise), 32'h00);
        check("rel_chg", 32'(bus.chg), 32'h1);

        // All pins low so later tests start from dout=0
        bus.din = 8'h00;
        tick(10);
        check("low_dout", 32'(bus.dout), 32'h00);
        check("low_fall", 32'(bus.fall), 32'hFF);
        tick(1);
        bus.chg_clr = 1'b1;
        tick(1);
        bus.chg_clr = 1'b0;
        check("clr_chg", 32'(bus.chg), 32'h0);

        // Glitch: 7 high clocks on bit 0 must not be accepted
        rise_cnt = 0;
        bad_lvl  = 0;
        bus.din[0] = 1'b1;
        for (int t = 0; t < 19; t++) begin
            if (t == 7) bus.din[0] = 1'b0;
            tick(1);
            if (bus.rise[0]) rise_cnt++;
            if (bus.dout[0]) bad_lvl++;
        end
        check("glitch_rise", 32'(rise_cnt), 32'd0);
        check("glitch_dout", 32'(bad_lvl), 32'd0);
        check("glitch_chg", 32'(bus.chg), 32'h0);

        // Clean step on bit 3
        bus.din[3] = 1'b1;
        tick(9);
        check("step_dout_early", 32'(bus.dout[3]), 32'h0);
        tick(1);
        check("step_dout", 32'(bus.dout), 32'h08);
        check("step_rise", 32'(bus.rise), 32'h08);
        check("step_chg_pre", 32'(bus.chg), 32'h0);
        tick(1);
        check("step_rise_off", 32'(bus.rise), 32'h00);
        check("step_chg", 32'(bus.chg), 32'h1);
        bus.chg_clr = 1'b1;
        tick(1);
        bus.chg_clr = 1'b0;

        // Bounce on bit 5: toggle every 3 clocks for 30 clocks, then settle high
        rise_cnt = 0;
        fall_cnt = 0;
        first    = 0;
        for (int seg = 0; seg < 10; seg++) begin
            bus.din[5] = (seg % 2 == 0);
            for (int t = 0; t < 3; t++) begin
                tick(1);
                if (bus.rise[5]) rise_cnt++;
                if (bus.fall[5]) fall_cnt++;
            end
        end
        bus.din[5] = 1'b1;
        for (int t = 1; t <= 13; t++) begin
            tick(1);
            if (bus.rise[5]) rise_cnt++;
            if (bus.fall[5]) fall_cnt++;
            if (bus.dout[5] && first == 0) first = t;
        end
        check("bounce_rise", 32'(rise_cnt), 32'd1);
        check("bounce_fall", 32'(fall_cnt), 32'd0);
        check("bounce_lat", 32'(first), 32'd10);
        check("bounce_dout", 32'(bus.dout), 32'h28);

        // Clear race: clear coincides with the cycle a fall pulse sets chg
        bus.din[2] = 1'b1;
        tick(11);
        check("race_up", 32'(bus.dout), 32'h2C);
        bus.din[2] = 1'b0;
        tick(9);
        check("race_fall_early", 32'(bus.fall), 32'h00);
        tick(1);
        check("race_fall", 32'(bus.fall), 32'h04);
        bus.chg_clr = 1'b1;
        tick(1);
        bus.chg_clr = 1'b0;
        check("race_chg_kept", 32'(bus.chg), 32'h1);
        bus.chg_clr = 1'b1;
        tick(1);
        bus.chg_clr = 1'b0;
        check("race_chg_clr", 32'(bus.chg), 32'h0);

        // Mid-debounce reset discards the partial count
        bus.din[1] = 1'b1;
        tick(7);
        check("mid_dout_pre", 32'(bus.dout), 32'h28);
        resetb = 1'b0;
        #1;
        check("mid_rst_dout", 32'(bus.dout), 32'h00);
        check("mid_rst_chg", 32'(bus.chg), 32'h0);
        tick(1);
        resetb = 1'b1;
        tick(9);
        check("mid_dout_early", 32'(bus.dout), 32'h00);
        tick(1);
        check("mid_dout", 32'(bus.dout), 32'h2A);
        check("mid_rise", 32'(bus.rise), 32'h2A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
